// File: rtl/icache_assoc_pkg.sv
// Shared cache definitions: bus width defaults, FSM encoding, clog2 and tree-PLRU helpers.
// Pure declarations, no latency or backpressure of its own; reused by the data cache.
package icache_assoc_pkg;

  localparam int ICACHE_AW = 16;
  localparam int ICACHE_RW = 16;
  localparam int ICACHE_IW = 32;
  localparam int PLRU_W    = 3;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Root bit picks the victim's low way bit; bit1 arbitrates ways 0/2, bit2 ways 1/3.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] s, input logic [1:0] w);
    logic [PLRU_W-1:0] n;
    n    = s;
    n[0] = ~w[0];
    if (w[0]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    return n;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [PLRU_W-1:0] s, input int ways);
    logic [1:0] v;
    v[0] = s[0];
    v[1] = s[0] ? s[2] : s[1];
    if (ways == 1)      v = 2'd0;
    else if (ways == 2) v[1] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: tag+line storage with 1-cycle synchronous read and per-set valid bits.
// Valid bits live here so a flush clears the whole way in a single edge; never stalls.
module icache_way_ram #(
  parameter int TAGW = 10,
  parameter int DW   = 128,
  parameter int SETS = 16,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            rd_en,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [DW-1:0]   rd_data,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [TAGW-1:0] wr_tag,
  input  logic [DW-1:0]   wr_data
);

  logic [TAGW+DW-1:0] mem [SETS];
  logic [SETS-1:0]    valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= {wr_tag, wr_data};
    if (rd_en) {rd_tag, rd_data} <= mem[rd_idx];
  end

  // Flush beats a simultaneous fill write so the line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (flush)      valid <= '0;
      else if (wr_en) valid[wr_idx] <= 1'b1;
      if (rd_en) rd_valid <= valid[rd_idx];
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative icache with Wishbone line fill; hit ack 2 cycles after accept, miss after burst.
// One request outstanding: mem_ready only in IDLE and never while a flush is requested.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int AW         = ICACHE_AW,
  parameter int RW         = ICACHE_RW,
  parameter int IW         = ICACHE_IW,
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_INSTR = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          mem_req,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  output logic          mem_ack,
  output logic [IW-1:0] mem_data,
  output logic          mem_err,
  input  logic          mem_cache_flush,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic [RW-1:0] wb_adr,
  output logic          wb_we,
  output logic [RW/8-1:0] wb_sel,
  input  logic [RW-1:0] wb_i_dat,
  input  logic          wb_ack,
  input  logic          wb_err
);

  localparam int IDXW  = clog2(SETS);
  localparam int OFFW  = clog2(LINE_INSTR);
  localparam int RATIO = IW / RW;
  localparam int BEATS = LINE_INSTR * RATIO;
  localparam int BW    = clog2(BEATS);
  localparam int TAGW  = AW - IDXW - OFFW;
  localparam int LW    = LINE_INSTR * IW;

  state_t            state, state_nxt;
  logic              armed, accept, hit, hit_ok, last_beat, flush_seen, fill_wr;
  logic [AW-1:0]     addr_q;
  logic [TAGW-1:0]   tag_q;
  logic [IDXW-1:0]   idx_q;
  logic [OFFW-1:0]   off_q;
  logic [BW-1:0]     beat;
  logic [1:0]        hit_way, victim, victim_q;
  logic [LW-1:0]     line_buf, line_nxt, hit_line;
  logic [RW-1:0]     line_base;
  logic [PLRU_W-1:0] plru [SETS];
  logic              rd_valid [WAYS];
  logic [TAGW-1:0]   rd_tag   [WAYS];
  logic [LW-1:0]     rd_data  [WAYS];

  assign tag_q     = addr_q[AW-1 -: TAGW];
  assign idx_q     = addr_q[OFFW +: IDXW];
  assign off_q     = addr_q[OFFW-1:0];
  assign mem_ready = armed && (state == S_IDLE) && !mem_cache_flush;
  assign accept    = mem_req && mem_ready;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign wb_cyc    = (state == S_FILL);
  assign wb_stb    = wb_cyc;
  assign wb_we     = 1'b0;
  assign wb_sel    = '1;
  assign line_base = RW'({tag_q, idx_q, {OFFW{1'b0}}}) * RW'(RATIO);
  assign wb_adr    = wb_cyc ? line_base + RW'(beat) : '0;
  assign fill_wr   = wb_cyc && wb_ack && !wb_err && last_beat && !flush_seen && !mem_cache_flush;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way_ram #(.TAGW(TAGW), .DW(LW), .SETS(SETS), .IDXW(IDXW)) u_ram (
      .clk(i_clk), .rst_n(i_rst_n), .flush(mem_cache_flush),
      .rd_en(accept), .rd_idx(mem_addr[OFFW +: IDXW]),
      .rd_valid(rd_valid[g]), .rd_tag(rd_tag[g]), .rd_data(rd_data[g]),
      .wr_en(fill_wr && (victim_q == 2'(g))), .wr_idx(idx_q), .wr_tag(tag_q), .wr_data(line_nxt)
    );
  end

  always_comb begin
    hit      = 1'b0;
    hit_way  = 2'd0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && (rd_tag[w] == tag_q)) begin
        hit      = 1'b1;
        hit_way  = w[1:0];
        hit_line = rd_data[w];
      end
    end
    hit_ok = hit && !mem_cache_flush;
    // Lowest-numbered invalid way takes priority over the PLRU choice.
    victim = plru_victim(plru[idx_q], WAYS);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) victim = w[1:0];
    end
  end

  always_comb begin
    line_nxt = line_buf;
    line_nxt[int'(beat)*RW +: RW] = wb_i_dat;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = hit_ok ? S_IDLE : S_FILL;
      S_FILL:   if (wb_err || (wb_ack && last_beat)) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed      <= 1'b0;
      addr_q     <= '0;
      beat       <= '0;
      line_buf   <= '0;
      victim_q   <= 2'd0;
      flush_seen <= 1'b0;
      mem_ack    <= 1'b0;
      mem_err    <= 1'b0;
      mem_data   <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      armed   <= 1'b1;
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      if (accept) addr_q <= mem_addr;
      case (state)
        S_LOOKUP: begin
          if (hit_ok) begin
            mem_ack     <= 1'b1;
            mem_data    <= hit_line[int'(off_q)*IW +: IW];
            plru[idx_q] <= plru_touch(plru[idx_q], hit_way);
          end else begin
            victim_q   <= victim;
            beat       <= '0;
            flush_seen <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_cache_flush) flush_seen <= 1'b1;
          if (wb_err) begin
            mem_ack <= 1'b1;
            mem_err <= 1'b1;
          end else if (wb_ack) begin
            line_buf <= line_nxt;
            beat     <= beat + BW'(1);
            // Requested instruction is forwarded from the fill path, not re-read.
            if (last_beat) begin
              mem_ack  <= 1'b1;
              mem_data <= line_nxt[int'(off_q)*IW +: IW];
              if (fill_wr) plru[idx_q] <= plru_touch(plru[idx_q], victim_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
